mem_arbiter: RTL

- Sits between the instruction-fetch cache (icache) and the load/store cache (dcache) on one side and the byte-wide main RAM / IO bus on the other.
- Latches one single-cycle request pulse per requester and arbitrates round-robin between them.
- Sequences each granted request as a 1/2/4-byte little-endian burst of byte accesses, then returns a one-cycle done pulse with the assembled data.
- Stalls IO-region writes while the UART buffer reports full.

---
 rtl/mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between icache and dcache for a byte-wide RAM/IO bus.
// Each granted request becomes a little-endian burst of 1, 2 or 4 byte accesses.
module mem_arbiter #(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_MASK = ADDR_W'(32'h0003_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              io_buffer_full,
    input  logic              ic_en,
    input  logic [ADDR_W-1:0] ic_pc,
    output logic              ic_done,
    output logic [31:0]       ic_dt,
    input  logic              dc_en,
    input  logic              dc_ls,
    input  logic [ADDR_W-1:0] dc_pc,
    input  logic [31:0]       dc_dt,
    input  logic [2:0]        dc_len,
    output logic              dc_done,
    output logic [31:0]       dc_dt_o,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 3;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;
    typedef enum logic {P_IC, P_DC} port_e;

    state_e              state_q, state_d;
    port_e               last_q, last_d;
    port_e               cur_port_q, cur_port_d;

    logic                ic_pend_q, ic_pend_d;
    logic [ADDR_W-1:0]   ic_addr_q, ic_addr_d;
    logic                dc_pend_q, dc_pend_d;
    logic                dc_ls_q, dc_ls_d;
    logic [ADDR_W-1:0]   dc_addr_q, dc_addr_d;
    logic [DATA_W-1:0]   dc_wdata_q, dc_wdata_d;
    logic [LEN_W-1:0]    dc_len_q, dc_len_d;

    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0]   cur_wdata_q, cur_wdata_d;
    logic [LEN_W-1:0]    cur_len_q, cur_len_d;
    logic [LEN_W-1:0]    k_q, k_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                ic_done_q, ic_done_d;
    logic                dc_done_q, dc_done_d;
    logic [DATA_W-1:0]   ic_dt_q, ic_dt_d;
    logic [DATA_W-1:0]   dc_dt_o_q, dc_dt_o_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                mem_wr_q, mem_wr_d;

    logic                grant_dc;
    logic                grant_wr;
    logic [ADDR_W-1:0]   byte_addr;
    logic [5:0]          rd_shift;
    logic [DATA_W-1:0]   rd_merge;
    logic [7:0]          wr_byte;

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return (a & IO_MASK) == IO_MASK;
    endfunction

    // Illegal lengths fall back to a full word.
    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] l);
        case (l)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte k of the burst; read data lags its address by one cycle.
    assign byte_addr = cur_addr_q + ADDR_W'(k_q);
    assign rd_shift  = {k_q - 3'd1, 3'b000};
    assign rd_merge  = rdata_q | (DATA_W'(mem_din) << rd_shift);
    assign wr_byte   = cur_wdata_q[{k_q[1:0], 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cur_port_d  = cur_port_q;
        ic_pend_d   = ic_pend_q;
        ic_addr_d   = ic_addr_q;
        dc_pend_d   = dc_pend_q;
        dc_ls_d     = dc_ls_q;
        dc_addr_d   = dc_addr_q;
        dc_wdata_d  = dc_wdata_q;
        dc_len_d    = dc_len_q;
        cur_addr_d  = cur_addr_q;
        cur_wdata_d = cur_wdata_q;
        cur_len_d   = cur_len_q;
        k_d         = k_q;
        rdata_d     = rdata_q;
        ic_done_d   = 1'b0;
        dc_done_d   = 1'b0;
        ic_dt_d     = ic_dt_q;
        dc_dt_o_d   = dc_dt_o_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        grant_dc    = 1'b0;
        grant_wr    = 1'b0;

        if (ic_en) begin
            ic_pend_d = 1'b1;
            ic_addr_d = ic_pc;
        end
        if (dc_en) begin
            dc_pend_d  = 1'b1;
            dc_ls_d    = dc_ls;
            dc_addr_d  = dc_pc;
            dc_wdata_d = dc_dt;
            dc_len_d   = norm_len(dc_len);
        end

        case (state_q)
            S_IDLE: begin
                if (ic_pend_d || dc_pend_d) begin
                    grant_dc = dc_pend_d && (!ic_pend_d || last_q == P_IC);
                    if (grant_dc) begin
                        dc_pend_d   = 1'b0;
                        last_d      = P_DC;
                        cur_port_d  = P_DC;
                        cur_addr_d  = dc_addr_d;
                        cur_wdata_d = dc_wdata_d;
                        cur_len_d   = dc_len_d;
                        grant_wr    = dc_ls_d;
                    end else begin
                        ic_pend_d   = 1'b0;
                        last_d      = P_IC;
                        cur_port_d  = P_IC;
                        cur_addr_d  = ic_addr_d;
                        cur_len_d   = 3'd4;
                    end
                    rdata_d = '0;
                    mem_a_d = cur_addr_d;
                    if (grant_wr) begin
                        state_d = S_WRITE;
                        if (is_io(cur_addr_d) && io_buffer_full) begin
                            k_d      = 3'd0;
                            mem_wr_d = 1'b0;
                        end else begin
                            k_d        = 3'd1;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = cur_wdata_d[7:0];
                        end
                    end else begin
                        state_d  = S_READ;
                        k_d      = 3'd0;
                        mem_wr_d = 1'b0;
                    end
                end
            end

            S_READ: begin
                if (k_q != 3'd0) begin
                    rdata_d = rd_merge;
                end
                if (k_q == cur_len_q) begin
                    state_d = S_IDLE;
                    mem_a_d = '0;
                    if (cur_port_q == P_IC) begin
                        ic_done_d = 1'b1;
                        ic_dt_d   = rd_merge;
                    end else begin
                        dc_done_d = 1'b1;
                        dc_dt_o_d = rd_merge;
                    end
                end else begin
                    k_d     = k_q + 3'd1;
                    mem_a_d = (k_q + 3'd1 == cur_len_q) ? '0 : byte_addr + ADDR_W'(1);
                end
            end

            S_WRITE: begin
                if (k_q == cur_len_q) begin
                    state_d   = S_IDLE;
                    mem_wr_d  = 1'b0;
                    mem_a_d   = '0;
                    dc_done_d = 1'b1;
                end else if (is_io(byte_addr) && io_buffer_full) begin
                    mem_wr_d = 1'b0;
                    mem_a_d  = byte_addr;
                end else begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = byte_addr;
                    mem_dout_d = wr_byte;
                    k_d        = k_q + 3'd1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                mem_wr_d = 1'b0;
                mem_a_d  = '0;
            end
        endcase
    end

    // All state frozen while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            last_q      <= P_IC;
            cur_port_q  <= P_IC;
            ic_pend_q   <= 1'b0;
            ic_addr_q   <= '0;
            dc_pend_q   <= 1'b0;
            dc_ls_q     <= 1'b0;
            dc_addr_q   <= '0;
            dc_wdata_q  <= '0;
            dc_len_q    <= '0;
            cur_addr_q  <= '0;
            cur_wdata_q <= '0;
            cur_len_q   <= '0;
            k_q         <= '0;
            rdata_q     <= '0;
            ic_done_q   <= 1'b0;
            dc_done_q   <= 1'b0;
            ic_dt_q     <= '0;
            dc_dt_o_q   <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            last_q      <= last_d;
            cur_port_q  <= cur_port_d;
            ic_pend_q   <= ic_pend_d;
            ic_addr_q   <= ic_addr_d;
            dc_pend_q   <= dc_pend_d;
            dc_ls_q     <= dc_ls_d;
            dc_addr_q   <= dc_addr_d;
            dc_wdata_q  <= dc_wdata_d;
            dc_len_q    <= dc_len_d;
            cur_addr_q  <= cur_addr_d;
            cur_wdata_q <= cur_wdata_d;
            cur_len_q   <= cur_len_d;
            k_q         <= k_d;
            rdata_q     <= rdata_d;
            ic_done_q   <= ic_done_d;
            dc_done_q   <= dc_done_d;
            ic_dt_q     <= ic_dt_d;
            dc_dt_o_q   <= dc_dt_o_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    assign ic_done  = ic_done_q;
    assign dc_done  = dc_done_q;
    assign ic_dt    = ic_dt_q;
    assign dc_dt_o  = dc_dt_o_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q & rdy;

endmodule
